// File: rtl/motor_cmd_deframer_pkg.sv
// motor_cmd_deframer_pkg: frame geometry and deframer state encoding shared with the status transmitter and top level.
package motor_cmd_deframer_pkg;
    localparam int MOTOR_NUM_CH = 10;
    localparam int DIV_W = 15;
    localparam int STEP_W = 14;
    localparam int CMD_FRAME_BYTES = 5;
    localparam int GAP_TIMEOUT = 2400;
    typedef enum logic [2:0] {IDLE, B1, B2, B3, B4} cmd_state_t;
endpackage

// File: rtl/motor_cmd_deframer_if.sv
// motor_cmd_deframer_if: receiver byte stream in, per-channel command registers and status out.
interface motor_cmd_deframer_if #(
    parameter int NUM_CH = motor_cmd_deframer_pkg::MOTOR_NUM_CH,
    parameter int DIV_W = motor_cmd_deframer_pkg::DIV_W,
    parameter int STEP_W = motor_cmd_deframer_pkg::STEP_W
);
    logic [7:0] rx_data;
    logic rx_ready;
    logic [NUM_CH-1:0] ch_active;
    logic [NUM_CH*DIV_W-1:0] divider;
    logic [NUM_CH*STEP_W-1:0] steps_to_go;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] load_strobe;
    logic frame_err;
    logic [NUM_CH-1:0] overflow;
    modport master (output rx_data, rx_ready, ch_active,
                    input divider, steps_to_go, pending, load_strobe, frame_err, overflow);
    modport slave (input rx_data, rx_ready, ch_active,
                   output divider, steps_to_go, pending, load_strobe, frame_err, overflow);
endinterface

// File: rtl/motor_cmd_deframer_slot.sv
// motor_cmd_deframer_slot: one channel's holding registers, pending/overflow flags and consume edge detect.
module motor_cmd_deframer_slot #(
    parameter int DIV_W = motor_cmd_deframer_pkg::DIV_W,
    parameter int STEP_W = motor_cmd_deframer_pkg::STEP_W
) (
    input  logic CLK,
    input  logic reset,
    input  logic commit_en,
    input  logic [DIV_W-1:0] commit_div,
    input  logic [STEP_W-1:0] commit_steps,
    input  logic active,
    output logic [DIV_W-1:0] divider,
    output logic [STEP_W-1:0] steps,
    output logic pending,
    output logic load_strobe,
    output logic overflow
);
    logic active_q, consume, accept;
    assign consume = active & ~active_q;
    // a start edge frees the slot in the same cycle, so a coincident commit is still taken
    assign accept = commit_en & (~pending | consume);
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            active_q <= 1'b0;
            divider <= '0;
            steps <= '0;
            pending <= 1'b0;
            load_strobe <= 1'b0;
            overflow <= 1'b0;
        end else begin
            active_q <= active;
            load_strobe <= accept;
            pending <= accept ? 1'b1 : consume ? 1'b0 : pending;
            overflow <= overflow | (commit_en & ~accept);
            if (accept) begin
                divider <= commit_div;
                steps <= commit_steps;
            end
        end
    end
endmodule

// File: rtl/motor_cmd_deframer.sv
// motor_cmd_deframer: assembles 5-byte command frames from the UART byte stream and routes them to per-channel slots.
module motor_cmd_deframer import motor_cmd_deframer_pkg::*; #(
    parameter int NUM_CH = motor_cmd_deframer_pkg::MOTOR_NUM_CH,
    parameter int DIV_W = motor_cmd_deframer_pkg::DIV_W,
    parameter int STEP_W = motor_cmd_deframer_pkg::STEP_W,
    parameter int GAP_TIMEOUT = motor_cmd_deframer_pkg::GAP_TIMEOUT
) (
    input logic CLK,
    input logic reset,
    motor_cmd_deframer_if.slave bus
);
    localparam int FW = DIV_W + STEP_W;
    localparam int GW = $clog2(GAP_TIMEOUT + 1);
    cmd_state_t state;
    logic rx_q, byte_pe, bad, commit_en, err;
    logic [3:0] ch;
    logic [23:0] word;
    logic [FW-1:0] commit_w;
    logic [GW-1:0] gap;
    logic [NUM_CH*DIV_W-1:0] div_v;
    logic [NUM_CH*STEP_W-1:0] steps_v;
    logic [NUM_CH-1:0] pend_v, ls_v, ovf_v;
    assign byte_pe = bus.rx_ready & ~rx_q;
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            rx_q <= 1'b0;
            ch <= '0;
            bad <= 1'b0;
            word <= '0;
            commit_w <= '0;
            commit_en <= 1'b0;
            gap <= '0;
            err <= 1'b0;
        end else begin
            rx_q <= bus.rx_ready;
            err <= 1'b0;
            commit_en <= 1'b0;
            gap <= (state == IDLE || byte_pe) ? '0 : gap + GW'(1);
            if (byte_pe) begin
                case (state)
                    IDLE: begin
                        ch <= bus.rx_data[3:0];
                        bad <= bus.rx_data >= 8'(NUM_CH);
                        err <= bus.rx_data >= 8'(NUM_CH);
                        state <= B1;
                    end
                    B1: begin word <= {bus.rx_data, word[23:8]}; state <= B2; end
                    B2: begin word <= {bus.rx_data, word[23:8]}; state <= B3; end
                    B3: begin word <= {bus.rx_data, word[23:8]}; state <= B4; end
                    default: begin
                        commit_en <= ~bad;
                        commit_w <= FW'({bus.rx_data, word});
                        state <= IDLE;
                    end
                endcase
            end else if (state != IDLE && gap == GW'(GAP_TIMEOUT)) begin
                err <= 1'b1;
                word <= '0;
                state <= IDLE;
            end
        end
    end
    for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
        motor_cmd_deframer_slot #(.DIV_W(DIV_W), .STEP_W(STEP_W)) u_slot (
            .CLK(CLK),
            .reset(reset),
            .commit_en(commit_en && ch == 4'(i)),
            .commit_div(commit_w[DIV_W-1:0]),
            .commit_steps(commit_w[FW-1:DIV_W]),
            .active(bus.ch_active[i]),
            .divider(div_v[i*DIV_W +: DIV_W]),
            .steps(steps_v[i*STEP_W +: STEP_W]),
            .pending(pend_v[i]),
            .load_strobe(ls_v[i]),
            .overflow(ovf_v[i])
        );
    end
    assign bus.divider = div_v;
    assign bus.steps_to_go = steps_v;
    assign bus.pending = pend_v;
    assign bus.load_strobe = ls_v;
    assign bus.overflow = ovf_v;
    assign bus.frame_err = err;
endmodule

// File: tb/tb_motor_cmd_deframer.sv
// tb_motor_cmd_deframer: directed frames with hand-computed register, flag and timing expectations.
module tb_motor_cmd_deframer;
    localparam int NUM_CH = 10;
    localparam int DIV_W = 15;
    localparam int STEP_W = 14;
    logic CLK = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;
    int err_cnt = 0;
    motor_cmd_deframer_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .STEP_W(STEP_W)) bus ();
    motor_cmd_deframer #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .STEP_W(STEP_W), .GAP_TIMEOUT(2400)) dut (
        .CLK(CLK),
        .reset(reset),
        .bus(bus)
    );
    always #5 CLK = ~CLK;
    always @(negedge CLK) if (bus.frame_err) err_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] div_of(input int c);
        return 32'(bus.divider[c*DIV_W +: DIV_W]);
    endfunction

    function automatic logic [31:0] steps_of(input int c);
        return 32'(bus.steps_to_go[c*STEP_W +: STEP_W]);
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        bus.rx_data = b;
        bus.rx_ready = 1'b1;
        @(negedge CLK);
        bus.rx_ready = 1'b0;
        @(negedge CLK);
    endtask

    task automatic frame(input logic [7:0] b0, b1, b2, b3, b4,
                         input logic [NUM_CH-1:0] exp_ls, input logic [NUM_CH-1:0] act);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        send_byte(b3);
        @(negedge CLK);
        bus.rx_data = b4;
        bus.rx_ready = 1'b1;
        @(negedge CLK);
        chk("ls_early", 32'(bus.load_strobe), 32'h0);
        bus.rx_ready = 1'b0;
        bus.ch_active = act;
        @(negedge CLK);
        chk("ls_lat2", 32'(bus.load_strobe), 32'(exp_ls));
        @(negedge CLK);
        chk("ls_one", 32'(bus.load_strobe), 32'h0);
    endtask

    initial begin
        int e0;
        bus.rx_data = 8'h00;
        bus.rx_ready = 1'b0;
        bus.ch_active = '0;
        repeat (3) @(negedge CLK);
        chk("rst_pend", 32'(bus.pending), 32'h0);
        chk("rst_ovf", 32'(bus.overflow), 32'h0);
        chk("rst_err", 32'(bus.frame_err), 32'h0);
        chk("rst_div", 32'(|bus.divider), 32'h0);
        reset = 1'b0;
        // 1: basic load
        frame(8'h03, 8'h10, 8'h80, 8'h02, 8'h00, 10'h008, 10'h000);
        chk("t1_div3", div_of(3), 32'h0010);
        chk("t1_stp3", steps_of(3), 32'h0005);
        chk("t1_pend", 32'(bus.pending), 32'h008);
        // 2: overflow while pending, consume, reload
        frame(8'h03, 8'h34, 8'h12, 8'h00, 8'h00, 10'h000, 10'h000);
        chk("t2_div3", div_of(3), 32'h0010);
        chk("t2_ovf", 32'(bus.overflow), 32'h008);
        @(negedge CLK);
        bus.ch_active = 10'h008;
        repeat (2) @(negedge CLK);
        chk("t2_cons", 32'(bus.pending), 32'h000);
        bus.ch_active = '0;
        frame(8'h03, 8'hFF, 8'h7F, 8'hFF, 8'h3F, 10'h008, 10'h000);
        chk("t2_div3b", div_of(3), 32'h7FFF);
        chk("t2_stp3b", steps_of(3), 32'h3FFE);
        chk("t2_pendb", 32'(bus.pending), 32'h008);
        // 3: bad channel byte swallows frame, alignment kept
        e0 = err_cnt;
        frame(8'h0C, 8'h00, 8'h00, 8'h00, 8'h00, 10'h000, 10'h000);
        chk("t3_err", 32'(err_cnt - e0), 32'd1);
        frame(8'h00, 8'h34, 8'h12, 8'h01, 8'h00, 10'h001, 10'h000);
        chk("t3_div0", div_of(0), 32'h1234);
        chk("t3_stp0", steps_of(0), 32'h0002);
        chk("t3_pend", 32'(bus.pending), 32'h009);
        // 4: gap timeout discards partial frame
        e0 = err_cnt;
        send_byte(8'h09);
        send_byte(8'h01);
        send_byte(8'h02);
        for (int i = 0; i < 3000 && err_cnt == e0; i++) @(negedge CLK);
        chk("t4_gap", 32'(err_cnt - e0), 32'd1);
        frame(8'h09, 8'hAA, 8'h55, 8'h07, 8'h00, 10'h200, 10'h000);
        chk("t4_div9", div_of(9), 32'h55AA);
        chk("t4_stp9", steps_of(9), 32'h000E);
        chk("t4_div0", div_of(0), 32'h1234);
        chk("t4_div3", div_of(3), 32'h7FFF);
        chk("t4_pend", 32'(bus.pending), 32'h209);
        // 5: commit coincident with consume
        frame(8'h05, 8'h01, 8'h00, 8'h00, 8'h00, 10'h020, 10'h000);
        chk("t5_pend_a", 32'(bus.pending), 32'h229);
        frame(8'h05, 8'h02, 8'h00, 8'h00, 8'h00, 10'h020, 10'h020);
        chk("t5_div5", div_of(5), 32'h0002);
        chk("t5_pend", 32'(bus.pending), 32'h229);
        chk("t5_ovf", 32'(bus.overflow), 32'h008);
        bus.ch_active = '0;
        // 6: asynchronous reset mid-frame
        send_byte(8'h01);
        send_byte(8'h11);
        @(negedge CLK);
        reset = 1'b1;
        #1;
        chk("t6_pend", 32'(bus.pending), 32'h0);
        chk("t6_ovf", 32'(bus.overflow), 32'h0);
        chk("t6_div", 32'(|bus.divider), 32'h0);
        chk("t6_stp", 32'(|bus.steps_to_go), 32'h0);
        @(negedge CLK);
        reset = 1'b0;
        frame(8'h01, 8'h21, 8'h43, 8'h01, 8'h00, 10'h002, 10'h000);
        chk("t6_div1", div_of(1), 32'h4321);
        chk("t6_stp1", steps_of(1), 32'h0002);
        chk("t6_pendb", 32'(bus.pending), 32'h002);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/motor_cmd_deframer.md
Name: motor_cmd_deframer

Overview:
Sits between the UART receiver (async_receiver) and the ten motor step controllers (motorCtrlSimple_v2).
- Assembles 5-byte command frames from the received byte stream.
- Routes each frame's divider/step-count to the addressed channel's holding register and tracks a per-channel pending flag.
- The pending flag is cleared when that channel's controller starts executing.
- The pending vector feeds the status transmitter.

Parameters:
NUM_CH, 10, number of motor channels (valid range 1..16)
DIV_W, 15, divider field width
STEP_W, 14, step-count field width
GAP_TIMEOUT, 2400, idle clocks between bytes before a partial frame is discarded (100 us at 24 MHz)

Ports:
CLK  in  1  system clock (24 MHz)
reset  in  1  asynchronous, active-high reset
rx_data  in  8  received byte, valid while rx_ready is high
rx_ready  in  1  receiver data-ready level; each rising edge delivers one byte
ch_active  in  NUM_CH  controller activeMode per channel
divider  out  NUM_CH*DIV_W  per-channel divider; channel i occupies [i*DIV_W +: DIV_W]
steps_to_go  out  NUM_CH*STEP_W  per-channel step count; channel i occupies [i*STEP_W +: STEP_W]
pending  out  NUM_CH  channel holds a loaded, not-yet-consumed command
load_strobe  out  NUM_CH  one-cycle pulse when a channel's registers are written
frame_err  out  1  one-cycle pulse on a bad channel byte or gap timeout
overflow  out  NUM_CH  sticky; a frame was dropped because the channel was pending

Behaviour:
Reset (async):
- All outputs and internal state go to 0; FSM goes to IDLE.
- rx_ready and ch_active edge-detect registers go to 0.

Byte strobe:
- byte_pe = rx_ready & ~rx_ready_q.
- Only byte_pe advances the FSM.

Frame format:
- Byte 0 is the channel number (0..NUM_CH-1).
- Bytes 1..4 form word W, little-endian (byte 1 = W[7:0]).
- Field mapping: divider = W[DIV_W-1:0]; steps = W[DIV_W+STEP_W-1:DIV_W]; the remaining upper bits are ignored.

FSM states: IDLE, B1, B2, B3, B4.
- IDLE: on byte_pe, latch ch = rx_data[3:0].
  - If rx_data >= NUM_CH: pulse frame_err and still go to B1. The frame is consumed and then discarded, which keeps byte alignment.
  - Otherwise go to B1.
- B1..B3: on byte_pe, shift the byte into the word register and advance one state.
- B4: on byte_pe, commit the frame (see Commit below) and return to IDLE.

Gap timeout:
- Gap counter resets on every byte_pe and counts while in B1..B4.
- When it reaches GAP_TIMEOUT: pulse frame_err, go to IDLE, and discard the partial word.
- The counter is held at 0 in IDLE.

Commit (cycle after the B4 byte_pe edge), for a valid channel c:
- If pending[c]==0, or a consume event for c occurs in the same cycle:
  - Write divider[c] and steps[c].
  - pending[c] <= 1 and load_strobe[c] <= 1 for one cycle.
- Otherwise: drop the frame, set overflow[c], leave registers unchanged.

Consume:
- ch_active rising edge on channel i (ch_active_q registered) sets pending[i] <= 0, unless a commit to i happens in the same cycle; in that case the commit wins and pending stays 1.
- The controller latches its inputs on its own start edge, so overwriting in that cycle is safe.

Other rules:
- Holding registers persist after consume; they are rewritten only by a commit.
- Latency: last byte's rx_ready rising edge to pending/load_strobe = 2 CLK (1 edge-detect + 1 commit).
- Back-to-back frames with no idle gap are supported; a byte_pe is never lost, including on the commit cycle.
- overflow bits clear only on reset.

Decomposition:
- Shared package: MOTOR_NUM_CH=10, DIV_W=15, STEP_W=14, CMD_FRAME_BYTES=5, and the FSM state encoding. These are shared with the status transmitter and the top level.
- One natural sub-module, motor_cmd_slot (instantiated NUM_CH times in a generate loop). It holds one channel's divider/steps registers, pending flag, overflow bit and consume edge-detect, with inputs commit_en, commit_div, commit_steps.

Test Plan:
1. Reset, then send frame {03, 0x10, 0x80, 0x02, 0x00}: W=0x00028010, divider[3]=0x0010, steps[3]=0x0005; pending=0x008; load_strobe[3] pulses once, 2 clocks after the last byte.
2. Second frame to ch3 while pending[3]=1: registers unchanged, overflow[3]=1, no load_strobe. Then pulse ch_active[3] 0->1: pending[3]=0. A third frame to ch3 loads normally.
3. Channel byte 0x0C: frame_err pulses at byte 0; the next 4 bytes are swallowed; then a valid frame to ch0 loads correctly (alignment retained).
4. Send 3 bytes, idle 2400 clocks: frame_err pulses, FSM returns to IDLE. A fresh frame to ch9 loads divider[9]/steps[9]; no other channel is touched.
5. Commit to ch5 in the same cycle as a ch_active[5] rising edge with pending[5]=1: frame accepted, pending[5] stays 1, overflow[5] stays 0.
6. Assert reset mid-frame (after byte 2): all outputs go to 0 immediately (asynchronously). After release, a full frame to ch1 loads correctly.
